// File: rtl/pipe_pkg.sv
// Shared pipeline-stage constants: side-channel indices and default widths
// used by the ready/go controllers between stage registers.
package pipe_pkg;

    localparam int CH_DIV     = 0;
    localparam int CH_MEM     = 1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NUM_CH = 2;
    localparam int DEF_CNT_W  = 2;

endpackage

// File: rtl/stage_cancel_cnt.sv
// Single-channel cancel counter: remembers how many responses of a flushed
// instruction are still in flight and swallows them as they arrive.
module stage_cancel_cnt
    import pipe_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic ch_done,
    input  logic cancel,
    output logic eff_done,
    output logic at_max
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] cnt;
    logic             dec;
    logic             inc;

    assign dec      = ch_done && (cnt != '0);
    assign inc      = cancel && (cnt != CMAX);
    assign eff_done = ch_done && (cnt == '0);
    assign at_max   = (cnt == CMAX);

    // A discard and a new cancel in the same cycle cancel each other out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/stage_readygo_ctrl.sv
// Pipeline-stage handshake controller: holds one instruction, collects sticky
// side-channel completions and drops responses belonging to flushed work.
module stage_readygo_ctrl
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0] in_need,
    output logic              allow_in,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_allow_in,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic              flush,
    output logic              ready_go
);

    logic              valid;
    logic [DATA_W-1:0] data;
    logic [NUM_CH-1:0] need;
    logic [NUM_CH-1:0] done_stk;
    logic [NUM_CH-1:0] eff_done;
    logic [NUM_CH-1:0] at_max;
    logic [NUM_CH-1:0] cancel;
    logic              accept;
    logic              leave;

    // Only channels still owed to the flushed instruction leave a response in flight.
    assign cancel = {NUM_CH{flush && valid}} & need & ~done_stk & ~ch_done;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        stage_cancel_cnt #(
            .CNT_W   (CNT_W)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .ch_done  (ch_done[i]),
            .cancel   (cancel[i]),
            .eff_done (eff_done[i]),
            .at_max   (at_max[i])
        );
    end

    assign ready_go  = valid && ((need & ~(done_stk | eff_done)) == '0);
    assign out_valid = ready_go;
    assign out_data  = data;
    assign allow_in  = !flush && (!valid || (ready_go && out_allow_in)) && !(|at_max);
    assign accept    = in_valid && allow_in;
    assign leave     = ready_go && out_allow_in && !accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid    <= 1'b0;
            data     <= '0;
            need     <= '0;
            done_stk <= '0;
        end else if (flush) begin
            valid    <= 1'b0;
            done_stk <= '0;
        end else if (accept) begin
            valid    <= 1'b1;
            data     <= in_data;
            need     <= in_need;
            done_stk <= '0;
        end else if (leave) begin
            valid    <= 1'b0;
            done_stk <= '0;
        end else if (valid) begin
            done_stk <= done_stk | (eff_done & need);
        end
    end

endmodule

// File: tb/tb_stage_readygo_ctrl.sv
// Table-driven bench for stage_readygo_ctrl with a payload scoreboard, plus a
// hand-written saturation sequence on a CNT_W=1 instance.
module tb_stage_readygo_ctrl;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] data;
        logic [1:0]  need;
        logic        oai;
        logic [1:0]  done;
        logic        flush;
        logic        drop;
        logic        exp_rg;
        logic        exp_ov;
        logic        exp_ai;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, allow_in, out_valid, out_allow_in, flush, ready_go;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_need, ch_done;

    logic        rst1, in_valid1, allow_in1, out_valid1, out_allow_in1, flush1, ready_go1;
    logic [31:0] in_data1, out_data1;
    logic [1:0]  in_need1, ch_done1;

    int          n_checks = 0;
    int          n_fails  = 0;
    vec_t        vecs[$];
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    stage_readygo_ctrl #(.DATA_W(32), .NUM_CH(2), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_need(in_need),
        .allow_in(allow_in), .out_valid(out_valid), .out_data(out_data),
        .out_allow_in(out_allow_in), .ch_done(ch_done), .flush(flush), .ready_go(ready_go)
    );

    stage_readygo_ctrl #(.DATA_W(32), .NUM_CH(2), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst1), .in_valid(in_valid1), .in_data(in_data1), .in_need(in_need1),
        .allow_in(allow_in1), .out_valid(out_valid1), .out_data(out_data1),
        .out_allow_in(out_allow_in1), .ch_done(ch_done1), .flush(flush1), .ready_go(ready_go1)
    );

    function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] d,
                                input logic [1:0] nd, input logic oai, input logic [1:0] dn,
                                input logic fl, input logic dr, input logic rg, input logic ov,
                                input logic ai, input logic cd, input logic [31:0] ed);
        vec_t v;
        v.rst = r; v.iv = iv; v.data = d; v.need = nd; v.oai = oai; v.done = dn;
        v.flush = fl; v.drop = dr; v.exp_rg = rg; v.exp_ov = ov; v.exp_ai = ai;
        v.chk_data = cd; v.exp_data = ed;
        return v;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst          = v.rst;
        in_valid     = v.iv;
        in_data      = v.data;
        in_need      = v.need;
        out_allow_in = v.oai;
        ch_done      = v.done;
        flush        = v.flush;
        if (v.drop && sb.size() > 0) void'(sb.pop_front());
        if (v.iv && v.exp_ai) sb.push_back(v.data);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("row%0d ready_go", idx), {31'b0, ready_go}, {31'b0, v.exp_rg});
        checkVal($sformatf("row%0d out_valid", idx), {31'b0, out_valid}, {31'b0, v.exp_ov});
        checkVal($sformatf("row%0d allow_in", idx), {31'b0, allow_in}, {31'b0, v.exp_ai});
        if (v.chk_data) checkVal($sformatf("row%0d out_data", idx), out_data, v.exp_data);
        if (out_valid && out_allow_in) begin
            if (sb.size() == 0) begin
                checkVal($sformatf("row%0d sb_underflow", idx), 32'd1, 32'd0);
            end else begin
                checkVal($sformatf("row%0d sb_data", idx), out_data, sb.pop_front());
            end
        end
    endtask

    task automatic drive1(input logic iv, input logic [31:0] d, input logic [1:0] nd,
                          input logic oai, input logic [1:0] dn, input logic fl);
        @(posedge clk);
        #1;
        in_valid1 = iv; in_data1 = d; in_need1 = nd;
        out_allow_in1 = oai; ch_done1 = dn; flush1 = fl;
        #2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 0; in_data = 0; in_need = 0; out_allow_in = 0; ch_done = 0; flush = 0;
        rst1 = 1'b1; in_valid1 = 0; in_data1 = 0; in_need1 = 0; out_allow_in1 = 0; ch_done1 = 0; flush1 = 0;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst1 = 1'b0;

        //              r iv data      nd oai dn fl dr  rg ov ai cd data
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 32'h0));
        // back-to-back need=0 traffic
        vecs.push_back(mk(0, 1, 32'hA5, 0, 1, 0, 0, 0,  0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 1, 32'hA6, 0, 1, 0, 0, 0,  1, 1, 1, 1, 32'hA5));
        vecs.push_back(mk(0, 1, 32'hA7, 0, 1, 0, 0, 0,  1, 1, 1, 1, 32'hA6));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  1, 1, 1, 1, 32'hA7));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        // sticky completion while downstream stalls
        vecs.push_back(mk(0, 1, 32'hB1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 2, 0, 0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 1, 0, 0,  1, 1, 0, 1, 32'hB1));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  1, 1, 1, 1, 32'hB1));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        // two channels completing at different cycles
        vecs.push_back(mk(0, 1, 32'hC1, 3, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 2, 0, 0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 1, 0, 0,  1, 1, 1, 1, 32'hC1));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        // flush with ch0 pending, stale response dropped
        vecs.push_back(mk(0, 1, 32'hD1, 1, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'hDF, 1, 1, 0, 1, 1,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'hD2, 1, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 1, 0, 0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 1, 0, 0,  1, 1, 1, 1, 32'hD2));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        // flush coinciding with the pending pulse leaves no count behind
        vecs.push_back(mk(0, 1, 32'hF1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'hFF, 1, 0, 1, 1, 1,  1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 32'hF2, 1, 0, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 1, 0, 0,  1, 1, 1, 1, 32'hF2));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        // reset with a ch1 cancel outstanding
        vecs.push_back(mk(0, 1, 32'h61, 2, 0, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 1, 1,  0, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 32'h0,  0, 0, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 0,  0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(0, 1, 32'h62, 2, 0, 0, 0, 0,  0, 0, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 2, 0, 0,  1, 1, 1, 1, 32'h62));
        vecs.push_back(mk(0, 0, 32'h0,  0, 1, 0, 0, 0,  0, 0, 1, 0, 32'h0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
            #2;
            checkOutput(vecs[i], i);
        end
        checkVal("sb_empty", sb.size(), 32'd0);

        // CNT_W=1: a single outstanding cancel saturates and blocks intake
        drive1(1, 32'h11, 2'b01, 0, 2'b00, 0);
        checkVal("w1 accept allow_in", {31'b0, allow_in1}, 32'd1);
        drive1(0, 32'h0, 2'b00, 0, 2'b00, 1);
        checkVal("w1 flush allow_in", {31'b0, allow_in1}, 32'd0);
        drive1(1, 32'h22, 2'b01, 0, 2'b00, 0);
        checkVal("w1 sat allow_in", {31'b0, allow_in1}, 32'd0);
        checkVal("w1 sat out_valid", {31'b0, out_valid1}, 32'd0);
        drive1(0, 32'h0, 2'b00, 0, 2'b00, 1);
        checkVal("w1 flush2 allow_in", {31'b0, allow_in1}, 32'd0);
        drive1(1, 32'h33, 2'b01, 0, 2'b01, 0);
        checkVal("w1 consume allow_in", {31'b0, allow_in1}, 32'd0);
        checkVal("w1 consume ready_go", {31'b0, ready_go1}, 32'd0);
        drive1(1, 32'h44, 2'b01, 0, 2'b00, 0);
        checkVal("w1 reopen allow_in", {31'b0, allow_in1}, 32'd1);
        checkVal("w1 reopen ready_go", {31'b0, ready_go1}, 32'd0);
        drive1(0, 32'h0, 2'b00, 1, 2'b01, 0);
        checkVal("w1 done ready_go", {31'b0, ready_go1}, 32'd1);
        checkVal("w1 done out_valid", {31'b0, out_valid1}, 32'd1);
        checkVal("w1 done out_data", out_data1, 32'h44);
        drive1(0, 32'h0, 2'b00, 1, 2'b00, 0);
        checkVal("w1 idle out_valid", {31'b0, out_valid1}, 32'd0);
        checkVal("w1 idle allow_in", {31'b0, allow_in1}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/stage_readygo_ctrl.md
# stage_readygo_ctrl

Parametrised pipeline-stage handshake controller, the successor to the single-bit EXE ready-go latch. It holds one instruction's payload and valid bit. It tracks completion of up to NUM_CH multi-cycle side channels (e.g. divider, data-SRAM request) with sticky per-channel done bits, and drives the stage's ready_go, out_valid and allow_in. On flush it counts responses still in flight and silently drops them when they arrive, so stale completions never satisfy a newer instruction. It sits between any two stage registers (EXE→MEM, MEM→WB).

## Interface
Parameters:
- DATA_W, 32, payload width held in the stage register
- NUM_CH, 2, number of completion channels (1..8)
- CNT_W, 2, width of each per-channel cancel counter; saturation value CMAX = 2^CNT_W-1

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream stage offers an instruction
- in_data  in  DATA_W  upstream payload
- in_need  in  NUM_CH  channels this instruction must wait for
- allow_in  out  1  this stage accepts this cycle
- out_valid  out  1  instruction valid and ready_go toward downstream
- out_data  out  DATA_W  registered payload
- out_allow_in  in  1  downstream accepts this cycle
- ch_done  in  NUM_CH  one-cycle completion pulse per channel
- flush  in  1  cancel the instruction held in this stage
- ready_go  out  1  all needed channels complete (valid-qualified)

## Operation
- State: valid, data[DATA_W], need[NUM_CH], done_stk[NUM_CH], cancel_cnt[NUM_CH][CNT_W].
- eff_done[i] = ch_done[i] && cancel_cnt[i]==0 (pulse not consumed by a cancel).
- ready_go = valid && ((need & ~(done_stk | eff_done)) == 0). A same-cycle pulse counts.
- out_valid = ready_go. out_data = data.
- allow_in = !flush && (!valid || (ready_go && out_allow_in)) && no cancel_cnt[i]==CMAX.
- accept = in_valid && allow_in: valid<=1, data<=in_data, need<=in_need, done_stk<=0.
- leave = ready_go && out_allow_in && !accept: valid<=0, done_stk<=0.
- Otherwise, while valid: done_stk <= done_stk | (eff_done & need). Sticky bits hold until the instruction leaves; the stage never loses a completion while downstream stalls.
- Per channel i, cancel_cnt:
  - decrements by 1 when ch_done[i] && cnt!=0; that pulse is discarded;
  - increments by 1 on flush when valid && need[i] && !done_stk[i] && !ch_done[i];
  - both in one cycle: net unchanged;
  - it never overflows, because allow_in is blocked at CMAX.
- flush: valid<=0, done_stk<=0, no accept that cycle. A flush on an empty stage only affects counters via decrement.
- A ch_done on an unneeded channel with cnt==0 is ignored. A ch_done with an empty stage and cnt==0 is ignored.

## Timing
- Reset values: valid=0, data=0, need=0, done_stk=0, all cancel_cnt=0. Hence out_valid=0, ready_go=0, allow_in=1, out_data=0.
- A need=0 instruction accepted at edge N shows out_valid in cycle N+1 (zero added latency).
- A ch_done pulse in cycle K with all other needs met gives ready_go combinationally in cycle K.
- Back-to-back throughput is 1/cycle when need=0 and out_allow_in=1: leave and accept happen on the same edge.
- rst mid-operation clears all state including the cancel counters. Responses arriving after reset are ignored.
- Priority: rst > flush > accept > leave/sticky update.

## Structure
- Shared package pipe_pkg: CH_DIV/CH_MEM channel index constants, default NUM_CH, CNT_W.
- One natural sub-module, stage_cancel_cnt: a single-channel saturating up/down counter with a consume output (eff_done). It is instantiated NUM_CH times via generate.
- Top level holds the stage register and the handshake logic.

## Test plan
- Reset, then in_valid=1, need=0, data=0xA5, out_allow_in=1 → out_valid in the next cycle with out_data=0xA5; allow_in stays 1, one instruction per cycle.
- need=2'b01, ch_done[0] pulses 3 cycles after accept while out_allow_in=0 for 5 cycles → ready_go rises with the pulse, holds sticky, and the instruction leaves on the first out_allow_in=1.
- need=2'b11, done[1] at cycle 2 and done[0] at cycle 4 → ready_go only from cycle 4.
- Flush at cycle 1 with need=2'b01 pending → cancel_cnt[0]=1. A new instruction needing ch0 is accepted. The late ch_done[0] is dropped and cnt returns to 0; the next ch_done[0] completes the new instruction.
- CNT_W=1: flush twice with ch0 pending → after the first flush cnt=CMAX and allow_in=0 until ch_done[0] is consumed.
- Same-cycle flush plus ch_done[0] for the pending channel → cnt stays 0 and nothing is accepted that cycle. Separately, rst asserted with cnt=1 → all state returns to reset values.
